// File: rtl/mlp_pkg.sv
// Shared constants for the MLP output stage: conversion modes, collector states
// and the word-index width helper.
package mlp_pkg;

   localparam int OUT_RELU   = 0;
   localparam int OUT_OFFSET = 1;
   localparam int OUT_RAW    = 2;

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] PENDING = 1'b1;

   localparam int NUM_NEURON_DEF = 10;
   localparam int IDX_W_DEF      = $clog2(NUM_NEURON_DEF);

   // Index width for a given neuron count; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/word_converter.sv
// Maps one signed neuron word onto an unsigned-comparable code for the max finder.
module word_converter
   import mlp_pkg::*;
#(
   parameter int dataWidth = 16,
   parameter int outMode   = OUT_RELU
) (
   input  logic [dataWidth-1:0] word_i,
   output logic [dataWidth-1:0] word_o
);

   always_comb begin
      word_o = word_i;
      case (outMode)
         OUT_RELU:   word_o = word_i[dataWidth-1] ? '0 : word_i;
         OUT_OFFSET: word_o = {~word_i[dataWidth-1], word_i[dataWidth-2:0]};
         default:    word_o = word_i;
      endcase
   end

endmodule

// File: rtl/layer_output_collector.sv
// Collects numNeuron converted words into one flat frame and releases it with a
// single-cycle pulse, holding frames back so pulses stay at least minGap apart.
module layer_output_collector
   import mlp_pkg::*;
#(
   parameter int numNeuron = 10,
   parameter int dataWidth = 16,
   parameter int outMode   = OUT_RELU,
   parameter int minGap    = 12
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [dataWidth-1:0]           i_data,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic                           i_abort,
   output logic [numNeuron*dataWidth-1:0] o_data,
   output logic                           o_valid,
   output logic                           o_overrun
);

   localparam int NN     = numNeuron;
   localparam int DW     = dataWidth;
   localparam int MG_EFF = (minGap < 1) ? 1 : minGap;
   localparam int IW     = idx_width(numNeuron);
   localparam int GW     = $clog2(MG_EFF + 1);

   logic [0:0]       state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [NN*DW-1:0] shadow_q, shadow_d;
   logic [NN*DW-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [GW-1:0]    elapsed;
   logic [DW-1:0]    conv_word;
   logic             accept;
   logic             gap_ok;

   word_converter #(
      .dataWidth (DW),
      .outMode   (outMode)
   ) u_conv (
      .word_i (i_data),
      .word_o (conv_word)
   );

   assign o_ready   = (state_q == COLLECT);
   assign o_data    = data_q;
   assign o_valid   = valid_q;
   assign o_overrun = overrun_q;

   assign accept = i_valid && o_ready && !i_abort;

   // Decision is made one cycle ahead of the pulse: a pulse in the next cycle is
   // legal when (cycles since last pulse + 1) reaches minGap.
   assign elapsed = valid_q ? '0 : gap_q;
   assign gap_ok  = ({1'b0, elapsed} + (GW+1)'(1)) >= (GW+1)'(MG_EFF);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      overrun_d = i_valid && !o_ready && !i_abort;
      gap_d     = gap_q;

      if (valid_q)
         gap_d = GW'(1);
      else if (gap_q < GW'(MG_EFF))
         gap_d = gap_q + GW'(1);

      if (state_q == COLLECT) begin
         if (i_abort) begin
            idx_d = '0;
         end else if (accept) begin
            shadow_d[int'(idx_q)*DW +: DW] = conv_word;
            if (idx_q == IW'(NN-1)) begin
               idx_d = '0;
               if (gap_ok) begin
                  data_d  = shadow_d;
                  valid_d = 1'b1;
               end else begin
                  state_d = PENDING;
               end
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
      end else begin
         // The held frame lives in the shadow until released or discarded.
         if (i_abort) begin
            state_d = COLLECT;
            idx_d   = '0;
         end else if (gap_ok) begin
            data_d  = shadow_q;
            valid_d = 1'b1;
            state_d = COLLECT;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= COLLECT;
         idx_q     <= '0;
         shadow_q  <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         gap_q     <= GW'(MG_EFF);
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         gap_q     <= gap_d;
      end
   end

endmodule

// File: tb/tb_layer_output_collector.sv
// Directed bench for layer_output_collector: three instances (ReLU, offset, raw)
// share one input stream; expected frames are written out by hand.
module tb_layer_output_collector;
   import mlp_pkg::*;

   localparam int NN = 10;
   localparam int DW = 16;
   localparam int VW = NN*DW;

   logic          clk = 1'b0;
   logic          i_rst;
   logic [DW-1:0] i_data;
   logic          i_valid;
   logic          i_abort;

   logic [VW-1:0] r_data, f_data, w_data;
   logic          r_ready, f_ready, w_ready;
   logic          r_valid, f_valid, w_valid;
   logic          r_ovr, f_ovr, w_ovr;

   int checks   = 0;
   int failures = 0;
   int n_wait;

   logic [DW-1:0] frm[NN];
   logic [DW-1:0] exp_r[NN];
   logic [DW-1:0] exp_f[NN];

   always #5 clk = ~clk;

   layer_output_collector #(.numNeuron(NN), .dataWidth(DW), .outMode(OUT_RELU), .minGap(12)) u_relu (
      .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(r_ready),
      .i_abort(i_abort), .o_data(r_data), .o_valid(r_valid), .o_overrun(r_ovr));

   layer_output_collector #(.numNeuron(NN), .dataWidth(DW), .outMode(OUT_OFFSET), .minGap(12)) u_off (
      .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(f_ready),
      .i_abort(i_abort), .o_data(f_data), .o_valid(f_valid), .o_overrun(f_ovr));

   layer_output_collector #(.numNeuron(NN), .dataWidth(DW), .outMode(OUT_RAW), .minGap(12)) u_raw (
      .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(w_ready),
      .i_abort(i_abort), .o_data(w_data), .o_valid(w_valid), .o_overrun(w_ovr));

   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [VW-1:0] pack(input logic [DW-1:0] w[NN]);
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < NN; k++) v[k*DW +: DW] = w[k];
      return v;
   endfunction

   function automatic logic [VW-1:0] mk_vec(input logic [DW-1:0] base);
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < NN; k++) v[k*DW +: DW] = base + DW'(k);
      return v;
   endfunction

   task automatic send_frm();
      for (int k = 0; k < NN; k++) begin
         i_valid = 1'b1;
         i_data  = frm[k];
         tick();
         if (k < NN-1) check("frm_early_valid", {159'b0, r_valid}, '0);
      end
      i_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [DW-1:0] base, input int n, input bit chk);
      for (int k = 0; k < n; k++) begin
         i_valid = 1'b1;
         i_data  = base + DW'(k);
         tick();
         if (chk && k < n-1) check("seq_early_valid", {159'b0, r_valid}, '0);
      end
      i_valid = 1'b0;
   endtask

   task automatic wait_valid(input int max_cyc, output int n);
      n = 0;
      while (r_valid !== 1'b1 && n < max_cyc) begin
         tick();
         n++;
      end
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_abort = 1'b0; i_data = '0;
      tick(); tick();
      i_rst = 1'b0;

      check("rst_data_relu",   r_data, '0);
      check("rst_data_off",    f_data, '0);
      check("rst_data_raw",    w_data, '0);
      check("rst_valid_relu",  {159'b0, r_valid}, '0);
      check("rst_valid_off",   {159'b0, f_valid}, '0);
      check("rst_valid_raw",   {159'b0, w_valid}, '0);
      check("rst_ready_relu",  {159'b0, r_ready}, 160'd1);
      check("rst_ready_off",   {159'b0, f_ready}, 160'd1);
      check("rst_ready_raw",   {159'b0, w_ready}, 160'd1);
      check("rst_ovr_relu",    {159'b0, r_ovr}, '0);
      check("rst_ovr_off",     {159'b0, f_ovr}, '0);
      check("rst_ovr_raw",     {159'b0, w_ovr}, '0);

      // Frame A: mixed signs, first frame goes out one cycle after its last word.
      frm   = '{16'h0005, 16'hFFFF, 16'h0010, 16'h8000, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
      exp_r = '{16'h0005, 16'h0000, 16'h0010, 16'h0000, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
      exp_f = '{16'h8005, 16'h7FFF, 16'h8010, 16'h0000, 16'h8003, 16'h8004, 16'h8005, 16'h8006, 16'h8007, 16'h8008};
      send_frm();
      check("a_valid_relu", {159'b0, r_valid}, 160'd1);
      check("a_valid_off",  {159'b0, f_valid}, 160'd1);
      check("a_data_relu",  r_data, pack(exp_r));
      check("a_data_off",   f_data, pack(exp_f));
      check("a_data_raw",   w_data, pack(frm));
      tick();
      check("a_pulse_width", {159'b0, r_valid}, '0);
      check("a_data_hold",   r_data, pack(exp_r));

      // Frame B: extreme words in slices 0 and 1.
      idle(12);
      frm   = '{16'h8000, 16'h7FFF, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
      exp_r = '{16'h0000, 16'h7FFF, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
      exp_f = '{16'h0000, 16'hFFFF, 16'h8001, 16'h8002, 16'h8003, 16'h8004, 16'h8005, 16'h8006, 16'h8007, 16'h8008};
      send_frm();
      check("b_valid_raw", {159'b0, w_valid}, 160'd1);
      check("b_data_relu", r_data, pack(exp_r));
      check("b_data_off",  f_data, pack(exp_f));
      check("b_data_raw",  w_data, pack(frm));

      // Back-to-back frames C and D, then an offered word while D is held.
      idle(12);
      for (int j = 0; j < 20; j++) begin
         i_valid = 1'b1;
         i_data  = (j < 10) ? 16'h0100 + DW'(j) : 16'h0200 + DW'(j - 10);
         tick();
         if (j == 9) begin
            check("c_valid_c10", {159'b0, r_valid}, 160'd1);
            check("c_data",      r_data, mk_vec(16'h0100));
         end
         if (j == 10) check("c_valid_c11", {159'b0, r_valid}, '0);
      end
      check("d_ready_c20", {159'b0, r_ready}, '0);
      check("d_valid_c20", {159'b0, r_valid}, '0);
      i_data = 16'h0BAD;
      tick();
      i_valid = 1'b0;
      check("d_ovr_c21",   {159'b0, r_ovr}, 160'd1);
      check("d_ready_c21", {159'b0, r_ready}, '0);
      check("d_valid_c21", {159'b0, r_valid}, '0);
      check("d_hold_c21",  r_data, mk_vec(16'h0100));
      tick();
      check("d_valid_c22", {159'b0, r_valid}, 160'd1);
      check("d_ready_c22", {159'b0, r_ready}, 160'd1);
      check("d_ovr_c22",   {159'b0, r_ovr}, '0);
      check("d_data",      r_data, mk_vec(16'h0200));
      send_seq(16'h0300, 10, 1'b0);
      check("e_held_valid", {159'b0, r_valid}, '0);
      check("e_held_ready", {159'b0, r_ready}, '0);
      wait_valid(10, n_wait);
      check("e_gap_wait", 160'(n_wait), 160'd2);
      check("e_data",     r_data, mk_vec(16'h0300));

      // Abort after four words in COLLECT.
      idle(12);
      send_seq(16'h0400, 4, 1'b1);
      i_abort = 1'b1; i_valid = 1'b1; i_data = 16'hEEEE;
      tick();
      i_abort = 1'b0; i_valid = 1'b0;
      check("ab_ovr",   {159'b0, r_ovr}, '0);
      check("ab_valid", {159'b0, r_valid}, '0);
      check("ab_hold",  r_data, mk_vec(16'h0300));
      send_seq(16'h0500, 10, 1'b1);
      check("ab_new_valid", {159'b0, r_valid}, 160'd1);
      check("ab_new_data",  r_data, mk_vec(16'h0500));

      // Abort while a frame is held back, with a simultaneous word.
      idle(12);
      send_seq(16'h0600, 10, 1'b1);
      check("pa_f_valid", {159'b0, r_valid}, 160'd1);
      send_seq(16'h0700, 10, 1'b0);
      check("pa_held_ready", {159'b0, r_ready}, '0);
      i_abort = 1'b1; i_valid = 1'b1; i_data = 16'hDDDD;
      tick();
      i_abort = 1'b0; i_valid = 1'b0;
      check("pa_ready", {159'b0, r_ready}, 160'd1);
      check("pa_ovr",   {159'b0, r_ovr}, '0);
      check("pa_valid", {159'b0, r_valid}, '0);
      check("pa_hold",  r_data, mk_vec(16'h0600));
      for (int i = 0; i < 4; i++) begin
         tick();
         check("pa_no_pulse", {159'b0, r_valid}, '0);
      end

      // Reset mid-frame, then a full frame goes out without gap delay.
      idle(3);
      send_seq(16'h0800, 6, 1'b1);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check("mr_data",  r_data, '0);
      check("mr_valid", {159'b0, r_valid}, '0);
      check("mr_ready", {159'b0, r_ready}, 160'd1);
      check("mr_ovr",   {159'b0, r_ovr}, '0);
      send_seq(16'h0900, 10, 1'b1);
      check("mr_new_valid", {159'b0, r_valid}, 160'd1);
      check("mr_new_data",  r_data, mk_vec(16'h0900));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
